// File: rtl/noc_flit_injector.sv
// noc_flit_injector: local-node transmitter that feeds one router input port.
//
// It accepts flits from a local source over a valid/ready handshake and picks
// a virtual channel for each packet. It keeps a credit counter for each VC's
// downstream buffer and only forwards a flit when the chosen VC can take it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   src_data/valid      flit from the local source
//   src_ready           flit accepted this cycle (combinational)
//   flit_data/valid/vch registered flit, valid and VC select to the router
//   vc_ack              per-VC credit return (one pulse per drained flit)
//   vc_rdy              per-VC buffer not full
//   vc_lck              per-VC allocated to another packet
//   busy                a multi-flit packet is in progress
//   proto_err           sticky protocol/credit error
//   stat_flits/pkts     sent-flit and sent-packet counters (INJ_STATS_EN only)
//
// Optional feature: define INJ_STATS_EN to add the stat_flits/stat_pkts ports.
module noc_flit_injector #(
  parameter int unsigned DATA_W    = 35,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] flit_data,
  output logic              flit_valid,
  output logic              flit_vch,
  input  logic [1:0]        vc_ack,
  input  logic [1:0]        vc_rdy,
  input  logic [1:0]        vc_lck,
  output logic              busy,
  output logic              proto_err
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]       stat_flits,
  output logic [15:0]       stat_pkts
`endif
);

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  localparam logic [1:0] TyBody     = 2'b00;
  localparam logic [1:0] TyHead     = 2'b01;
  localparam logic [1:0] TyTail     = 2'b10;
  localparam logic [1:0] TyHeadTail = 2'b11;

  localparam logic [CNT_W-1:0] CreditMax = CNT_W'(BUF_DEPTH);

  state_e state_q, state_d;
  logic   cur_vc_q, cur_vc_d;
  logic   last_vc_q, last_vc_d;
  logic   proto_err_q;

  logic [CNT_W-1:0] credit_q [2];
  logic [CNT_W-1:0] credit_d [2];

  logic [DATA_W-1:0] flit_data_q;
  logic              flit_valid_q;
  logic              flit_vch_q;

  logic [1:0] typ;
  logic [1:0] elig;
  logic       pick_vc;
  logic       accept;
  logic       send;
  logic       send_vc;
  logic       fsm_err;
  logic       ack_ovf;

  assign typ = src_data[DATA_W-1 -: 2];

  // A VC may take a new head only if it has room and nobody else owns it.
  always_comb begin
    for (int v = 0; v < 2; v++) begin
      elig[v] = (credit_q[v] != '0) && vc_rdy[v] && !vc_lck[v];
    end
  end

  // Exactly one eligible: use it. Both eligible: alternate away from last_vc.
  always_comb begin
    if (elig == 2'b11) begin
      pick_vc = ~last_vc_q;
    end else begin
      pick_vc = elig[1];
    end
  end

  // Inside a packet the lock is ours, so only credit and ready matter.
  always_comb begin
    src_ready = 1'b0;
    if (!rst) begin
      if (state_q == StIdle) begin
        src_ready = |elig;
      end else begin
        src_ready = (credit_q[cur_vc_q] != '0) && vc_rdy[cur_vc_q];
      end
    end
  end

  assign accept = src_valid && src_ready;

  // FSM next-state and send decision.
  always_comb begin
    state_d   = state_q;
    cur_vc_d  = cur_vc_q;
    last_vc_d = last_vc_q;
    send      = 1'b0;
    send_vc   = cur_vc_q;
    fsm_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (typ)
            TyHead: begin
              send      = 1'b1;
              send_vc   = pick_vc;
              cur_vc_d  = pick_vc;
              last_vc_d = pick_vc;
              state_d   = StPkt;
            end
            TyHeadTail: begin
              send      = 1'b1;
              send_vc   = pick_vc;
              last_vc_d = pick_vc;
            end
            default: fsm_err = 1'b1;  // stray body/tail is dropped
          endcase
        end
      end
      StPkt: begin
        if (accept) begin
          send = 1'b1;
          unique case (typ)
            TyBody: ;
            TyTail: state_d = StIdle;
            TyHead: fsm_err = 1'b1;
            TyHeadTail: begin
              fsm_err = 1'b1;
              state_d = StIdle;
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Credits: send decrements, ack increments, both together cancel out.
  always_comb begin
    ack_ovf = 1'b0;
    for (int v = 0; v < 2; v++) begin
      credit_d[v] = credit_q[v];
      if (send && (send_vc == 1'(v))) begin
        if (!vc_ack[v]) begin
          credit_d[v] = credit_q[v] - 1'b1;
        end
      end else if (vc_ack[v]) begin
        if (credit_q[v] == CreditMax) begin
          ack_ovf = 1'b1;  // saturate rather than wrap
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_vc_q     <= 1'b0;
      last_vc_q    <= 1'b1;
      proto_err_q  <= 1'b0;
      credit_q[0]  <= CreditMax;
      credit_q[1]  <= CreditMax;
      flit_data_q  <= '0;
      flit_valid_q <= 1'b0;
      flit_vch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_vc_q     <= cur_vc_d;
      last_vc_q    <= last_vc_d;
      proto_err_q  <= proto_err_q | fsm_err | ack_ovf;
      credit_q[0]  <= credit_d[0];
      credit_q[1]  <= credit_d[1];
      flit_valid_q <= send;
      if (send) begin
        flit_data_q <= src_data;
        flit_vch_q  <= send_vc;
      end
    end
  end

  assign flit_data  = flit_data_q;
  assign flit_valid = flit_valid_q;
  assign flit_vch   = flit_vch_q;
  assign busy       = (state_q == StPkt);
  assign proto_err  = proto_err_q;

`ifdef INJ_STATS_EN
  logic [15:0] stat_flits_q;
  logic [15:0] stat_pkts_q;

  // Both counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits_q <= '0;
      stat_pkts_q  <= '0;
    end else if (send) begin
      stat_flits_q <= stat_flits_q + 16'd1;
      if (typ[1]) begin
        stat_pkts_q <= stat_pkts_q + 16'd1;
      end
    end
  end

  assign stat_flits = stat_flits_q;
  assign stat_pkts  = stat_pkts_q;
`endif

endmodule
